// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: operation codes, flash command bytes and state encodings shared by the sequencer
package spi_flash_pkg;
   typedef enum logic [2:0] {OP_READ_ID, OP_READ_SR, OP_READ, OP_PAGE_PROG, OP_SECTOR_ERASE} op_e;
   localparam logic [7:0] CMD_RDID = 8'h9F;
   localparam logic [7:0] CMD_RDSR = 8'h05;
   localparam logic [7:0] CMD_READ = 8'h03;
   localparam logic [7:0] CMD_PP   = 8'h02;
   localparam logic [7:0] CMD_SE   = 8'hD8;
   localparam logic [7:0] CMD_WREN = 8'h06;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WREN, S_CMD, S_POLL, S_DONE} state_e;
   typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_WAIT_HI, T_WAIT_LO} txn_e;
   function automatic logic [7:0] op_cmd(input logic [2:0] c);
      return c == OP_READ_ID ? CMD_RDID : c == OP_READ_SR ? CMD_RDSR : c == OP_READ ? CMD_READ :
             c == OP_PAGE_PROG ? CMD_PP : CMD_SE;
   endfunction
endpackage

// File: rtl/spi_flash_seq_if.sv
// spi_flash_seq_if: host-side operation request, program-data stream and completion response
interface spi_flash_seq_if;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_code;
   logic [23:0] op_addr;
   logic [11:0] op_len;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_data;
   logic        rsp_valid;
   logic [63:0] rsp_data;
   logic        rsp_err;
   modport master (output op_valid, op_code, op_addr, op_len, wr_valid, wr_data,
                   input op_ready, wr_ready, rsp_valid, rsp_data, rsp_err);
   modport slave (input op_valid, op_code, op_addr, op_len, wr_valid, wr_data,
                  output op_ready, wr_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/spi_txn_issue.sv
// spi_txn_issue: one engine transaction; trigger once the engine is idle, then wait for busy to rise and fall
module spi_txn_issue
   import spi_flash_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic busy,
   output logic trigger,
   output logic done
);
   txn_e st;
   assign done = st == T_WAIT_LO && !busy;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st <= T_IDLE;
         trigger <= 1'b0;
      end else begin
         trigger <= st == T_ISSUE && !busy;
         case (st)
            T_IDLE:    if (start) st <= T_ISSUE;
            T_ISSUE:   if (!busy) st <= T_WAIT_HI;
            T_WAIT_HI: if (busy) st <= T_WAIT_LO;
            default:   if (!busy) st <= T_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: turns flash operations into SPI engine transactions, adding write-enable and status polling
module spi_flash_seq
   import spi_flash_pkg::*;
#(
   parameter int          MAXCMD   = 256,
   parameter logic [19:0] POLL_MAX = 20'd1000000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   spi_flash_seq_if.slave            host,
   output logic                      trigger,
   input  logic                      busy,
   output logic [11:0]               data_in_count,
   output logic [11:0]               data_out_count,
   output logic [(4+MAXCMD)*8-1:0]   data_in,
   input  logic [63:0]               data_out,
   output logic                      quad
);
   localparam int W = (4 + MAXCMD) * 8;
   state_e      st;
   logic [2:0]  code;
   logic [11:0] len, bcnt, rxb, txc, oc;
   logic [W-1:0] pay, fr;
   logic [20:0] pcnt, pn;
   logic [63:0] mask;
   logic        start, act, done, bad, short_cmd;
   assign quad = 1'b0;
   assign short_cmd = host.op_code == OP_READ_ID || host.op_code == OP_READ_SR;
   assign bad = host.op_code > 3'd4 ||
                (host.op_code == OP_READ && (host.op_len == 12'd0 || host.op_len > 12'd8)) ||
                (host.op_code == OP_PAGE_PROG && (host.op_len == 12'd0 || host.op_len > 12'(MAXCMD)));
   assign rxb = code == OP_READ_ID ? 12'd3 : code == OP_READ_SR ? 12'd1 : code == OP_READ ? len : 12'd0;
   assign txc = code == OP_READ_ID || code == OP_READ_SR ? 12'd7 : code == OP_PAGE_PROG ? 12'd31 + (len << 3) : 12'd31;
   assign oc = st == S_WREN ? 12'd0 : st == S_POLL ? 12'd8 : rxb << 3;
   assign fr = st == S_WREN ? W'(CMD_WREN) : st == S_POLL ? W'(CMD_RDSR) : pay;
   // 65-bit shift so an 8-byte read yields an all-ones mask
   assign mask = 64'((65'd1 << {rxb[3:0], 3'b000}) - 65'd1);
   assign pn = pcnt + 21'd1;
   spi_txn_issue u_txn (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .trigger(trigger), .done(done)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st <= S_IDLE;
         code <= '0;
         len <= '0;
         bcnt <= '0;
         pay <= '0;
         pcnt <= '0;
         start <= 1'b0;
         act <= 1'b0;
         data_in <= '0;
         data_in_count <= '0;
         data_out_count <= '0;
         host.op_ready <= 1'b0;
         host.wr_ready <= 1'b0;
         host.rsp_valid <= 1'b0;
         host.rsp_err <= 1'b0;
         host.rsp_data <= '0;
      end else begin
         start <= 1'b0;
         host.rsp_valid <= 1'b0;
         case (st)
            S_IDLE: if (host.op_valid && host.op_ready) begin
               host.op_ready <= 1'b0;
               code <= host.op_code;
               len <= host.op_len;
               bcnt <= '0;
               pcnt <= '0;
               pay <= short_cmd ? W'(op_cmd(host.op_code)) : W'({op_cmd(host.op_code), host.op_addr});
               host.wr_ready <= !bad && host.op_code == OP_PAGE_PROG;
               host.rsp_valid <= bad;
               host.rsp_err <= bad;
               host.rsp_data <= '0;
               st <= bad ? S_DONE : host.op_code == OP_PAGE_PROG ? S_LOAD :
                     host.op_code == OP_SECTOR_ERASE ? S_WREN : S_CMD;
            end else host.op_ready <= 1'b1;
            S_LOAD: if (host.wr_valid && host.wr_ready) begin
               pay <= {pay[W-9:0], host.wr_data};
               bcnt <= bcnt + 12'd1;
               if (bcnt == len - 12'd1) begin
                  host.wr_ready <= 1'b0;
                  st <= S_WREN;
               end
            end
            S_DONE: begin
               host.op_ready <= 1'b1;
               st <= S_IDLE;
            end
            default: if (!act) begin
               act <= 1'b1;
               start <= 1'b1;
               data_in <= fr;
               data_in_count <= st == S_CMD ? txc : 12'd7;
               data_out_count <= oc;
            end else if (done) begin
               act <= 1'b0;
               if (st == S_WREN) st <= S_CMD;
               else if (st == S_CMD && rxb == 12'd0) st <= S_POLL;
               else if (st == S_CMD || !data_out[0] || pn > {1'b0, POLL_MAX}) begin
                  host.rsp_valid <= 1'b1;
                  host.rsp_err <= st == S_POLL && data_out[0];
                  host.rsp_data <= st == S_CMD ? data_out & mask : 64'd0;
                  st <= S_DONE;
               end else pcnt <= pn;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq: scoreboard bench with a behavioural SPI engine driving directed flash operations
module tb_spi_flash_seq;
   localparam int MAXCMD = 256;
   localparam int W = (4 + MAXCMD) * 8;
   typedef struct {
      logic [63:0] frame;
      logic [11:0] din_cnt;
      logic [11:0] dout_cnt;
      logic [63:0] resp;
   } txn_t;
   typedef struct {
      logic [63:0] data;
      logic        err;
   } rsp_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic busy = 1'b1;
   logic trigger, quad;
   logic [11:0] data_in_count, data_out_count;
   logic [W-1:0] data_in;
   logic [63:0] data_out = '0;
   int checks = 0;
   int failures = 0;
   int trig_cnt = 0;
   txn_t exp_txn[$];
   rsp_t exp_rsp[$];
   logic [7:0] wr_q[$];
   spi_flash_seq_if ifc();
   spi_flash_seq #(.MAXCMD(MAXCMD), .POLL_MAX(20'd4)) dut (
      .clk(clk), .reset_n(reset_n), .host(ifc), .trigger(trigger), .busy(busy),
      .data_in_count(data_in_count), .data_out_count(data_out_count),
      .data_in(data_in), .data_out(data_out), .quad(quad)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   task automatic tx(input logic [63:0] f, input logic [11:0] di, input logic [11:0] dc, input logic [63:0] r);
      txn_t t;
      t.frame = f;
      t.din_cnt = di;
      t.dout_cnt = dc;
      t.resp = r;
      exp_txn.push_back(t);
   endtask
   task automatic rs(input logic [63:0] d, input logic e);
      rsp_t r;
      r.data = d;
      r.err = e;
      exp_rsp.push_back(r);
   endtask
   task automatic check_reset(input string tag);
      chk({tag, "_trigger"}, 64'(trigger), 64'd0);
      chk({tag, "_op_ready"}, 64'(ifc.op_ready), 64'd0);
      chk({tag, "_wr_ready"}, 64'(ifc.wr_ready), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(ifc.rsp_valid), 64'd0);
      chk({tag, "_rsp_err"}, 64'(ifc.rsp_err), 64'd0);
      chk({tag, "_rsp_data"}, ifc.rsp_data, 64'd0);
      chk({tag, "_din_cnt"}, 64'(data_in_count), 64'd0);
      chk({tag, "_dout_cnt"}, 64'(data_out_count), 64'd0);
      chk({tag, "_data_in"}, 64'(|data_in), 64'd0);
      chk({tag, "_quad"}, 64'(quad), 64'd0);
   endtask
   task automatic send_op(input logic [2:0] c, input logic [23:0] a, input logic [11:0] l);
      int n = 0;
      @(negedge clk);
      ifc.op_valid = 1'b1;
      ifc.op_code = c;
      ifc.op_addr = a;
      ifc.op_len = l;
      while (!ifc.op_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("op_accept", 64'(ifc.op_ready), 64'd1);
      @(negedge clk);
      ifc.op_valid = 1'b0;
   endtask
   task automatic wait_done(input string name);
      int n = 0;
      while ((exp_rsp.size() != 0 || exp_txn.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drained"}, 64'(exp_rsp.size() + exp_txn.size()), 64'd0);
      exp_rsp.delete();
      exp_txn.delete();
      @(negedge clk);
   endtask
   always @(negedge clk) if (trigger) chk("trig_busy_low", 64'(busy), 64'd0);
   // response scoreboard
   always @(negedge clk) if (ifc.rsp_valid) begin
      rsp_t r;
      if (exp_rsp.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_rsp data=%h err=%b required=none", ifc.rsp_data, ifc.rsp_err);
      end else begin
         r = exp_rsp.pop_front();
         chk("rsp_data", ifc.rsp_data, r.data);
         chk("rsp_err", 64'(ifc.rsp_err), 64'(r.err));
      end
   end
   // engine model: busy after its own reset, then serves each trigger for a few cycles
   initial begin
      @(posedge reset_n);
      repeat (10) @(posedge clk);
      #1 busy = 1'b0;
      forever begin
         @(negedge clk);
         if (trigger) begin
            txn_t t;
            t.resp = '0;
            trig_cnt++;
            if (exp_txn.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_txn frame=%h required=none", data_in[63:0]);
            end else begin
               t = exp_txn.pop_front();
               chk("frame", data_in[63:0], t.frame);
               chk("frame_hi_zero", 64'(|data_in[W-1:64]), 64'd0);
               chk("din_cnt", 64'(data_in_count), 64'(t.din_cnt));
               chk("dout_cnt", 64'(data_out_count), 64'(t.dout_cnt));
            end
            @(posedge clk);
            #1 busy = 1'b1;
            repeat (3) @(posedge clk);
            #1 data_out = t.resp;
            busy = 1'b0;
         end
      end
   end
   initial begin
      ifc.wr_valid = 1'b0;
      ifc.wr_data = 8'h00;
      forever begin
         @(negedge clk);
         ifc.wr_valid = wr_q.size() != 0;
         ifc.wr_data = wr_q.size() != 0 ? wr_q[0] : 8'h00;
         @(posedge clk);
         if (ifc.wr_valid && ifc.wr_ready) void'(wr_q.pop_front());
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end
   initial begin
      int base;
      int n;
      ifc.op_valid = 1'b0;
      ifc.op_code = '0;
      ifc.op_addr = '0;
      ifc.op_len = '0;
      repeat (2) @(negedge clk);
      check_reset("por");
      reset_n = 1'b1;
      #1 chk("op_ready_at_release", 64'(ifc.op_ready), 64'd0);
      tx(64'h9F, 12'd7, 12'd24, 64'hDEADBEEF00EF4018);
      rs(64'hEF4018, 1'b0);
      send_op(3'd0, 24'h0, 12'd0);
      wait_done("read_id");
      tx(64'h03012345, 12'd31, 12'd32, 64'h1122334455667788);
      rs(64'h55667788, 1'b0);
      send_op(3'd2, 24'h012345, 12'd4);
      wait_done("read4");
      tx(64'h03ABCDEF, 12'd31, 12'd64, 64'h0123456789ABCDEF);
      rs(64'h0123456789ABCDEF, 1'b0);
      send_op(3'd2, 24'hABCDEF, 12'd8);
      wait_done("read8");
      tx(64'h05, 12'd7, 12'd8, 64'hFFFFFF5A);
      rs(64'h5A, 1'b0);
      send_op(3'd1, 24'hFFFFFF, 12'd0);
      wait_done("read_sr");
      wr_q.push_back(8'hA5);
      wr_q.push_back(8'h5A);
      tx(64'h06, 12'd7, 12'd0, 64'h0);
      tx(64'h02000100A55A, 12'd47, 12'd0, 64'h0);
      tx(64'h05, 12'd7, 12'd8, 64'h03);
      tx(64'h05, 12'd7, 12'd8, 64'h03);
      tx(64'h05, 12'd7, 12'd8, 64'h00);
      rs(64'h0, 1'b0);
      send_op(3'd3, 24'h000100, 12'd2);
      wait_done("page_prog");
      base = trig_cnt;
      tx(64'h06, 12'd7, 12'd0, 64'h0);
      tx(64'hD8123000, 12'd31, 12'd0, 64'h0);
      for (int i = 0; i < 5; i++) tx(64'h05, 12'd7, 12'd8, 64'h01);
      rs(64'h0, 1'b1);
      send_op(3'd4, 24'h123000, 12'd0);
      wait_done("erase_timeout");
      chk("erase_txn_count", 64'(trig_cnt - base), 64'd7);
      base = trig_cnt;
      rs(64'h0, 1'b1);
      send_op(3'd6, 24'h0, 12'd1);
      wait_done("illegal_code");
      rs(64'h0, 1'b1);
      send_op(3'd2, 24'h0, 12'd9);
      wait_done("read_len9");
      rs(64'h0, 1'b1);
      send_op(3'd3, 24'h0, 12'd0);
      wait_done("prog_len0");
      rs(64'h0, 1'b1);
      send_op(3'd3, 24'h0, 12'd257);
      wait_done("prog_len257");
      chk("illegal_no_trigger", 64'(trig_cnt - base), 64'd0);
      base = trig_cnt;
      wr_q.push_back(8'h11);
      wr_q.push_back(8'h22);
      wr_q.push_back(8'h33);
      tx(64'h06, 12'd7, 12'd0, 64'h0);
      tx(64'h02000200112233, 12'd55, 12'd0, 64'h0);
      tx(64'h05, 12'd7, 12'd8, 64'h00);
      rs(64'h0, 1'b0);
      send_op(3'd3, 24'h000200, 12'd3);
      n = 0;
      while (trig_cnt < base + 2 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_cmd", 64'(trig_cnt - base), 64'd2);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1 check_reset("abort");
      exp_txn.delete();
      exp_rsp.delete();
      wr_q.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1 chk("op_ready_after_abort", 64'(ifc.op_ready), 64'd0);
      tx(64'h05, 12'd7, 12'd8, 64'h42);
      rs(64'h42, 1'b0);
      send_op(3'd1, 24'h0, 12'd0);
      wait_done("read_sr_after_abort");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
